// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and EXE-side update signals of the set-associative BTB.
// The slave modport is the BTB side; the master modport is the fetch/EXE side.
interface btb_assoc_if #(
    parameter int XLEN_WIDTH  = 32,
    parameter int FETCH_WIDTH = 2
);
    logic                              flush;
    logic [FETCH_WIDTH*XLEN_WIDTH-1:0] fetch_pc;
    logic [FETCH_WIDTH-1:0]            btb_hit;
    logic [FETCH_WIDTH-1:0]            btb_taken;
    logic [FETCH_WIDTH*XLEN_WIDTH-1:0] btb_target;
    logic                              branch_valid;
    logic                              branch_taken;
    logic [XLEN_WIDTH-1:0]             branch_addr;
    logic [XLEN_WIDTH-1:0]             branch_target_addr;

    modport master (
        output flush, fetch_pc, branch_valid, branch_taken, branch_addr, branch_target_addr,
        input  btb_hit, btb_taken, btb_target
    );

    modport slave (
        input  flush, fetch_pc, branch_valid, branch_taken, branch_addr, branch_target_addr,
        output btb_hit, btb_taken, btb_target
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational multi-lane lookup, registered
// update with 2-bit direction counters, round-robin replacement and single-cycle flush.
module btb_assoc #(
    parameter int XLEN_WIDTH  = 32,
    parameter int ENTRY_NUM   = 64,
    parameter int WAYS        = 2,
    parameter int FETCH_WIDTH = 2,
    parameter int CNT_INIT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    btb_assoc_if.slave  bus
);
    localparam int SETS = ENTRY_NUM / WAYS;
    localparam int IDX  = (SETS > 1) ? $clog2(SETS) : 0;
    localparam int IW   = (IDX > 0) ? IDX : 1;
    localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TW   = XLEN_WIDTH - IDX - 2;
    localparam int GW   = XLEN_WIDTH - 2;

    logic          r_valid [SETS][WAYS];
    logic [TW-1:0] r_tag   [SETS][WAYS];
    logic [GW-1:0] r_tgt   [SETS][WAYS];
    logic [1:0]    r_cnt   [SETS][WAYS];
    logic [WB-1:0] r_rr    [SETS];

    function automatic logic [IW-1:0] f_idx(input logic [XLEN_WIDTH-1:0] pc);
        return IW'(pc >> 2) & IW'(SETS - 1);
    endfunction

    function automatic logic [TW-1:0] f_tag(input logic [XLEN_WIDTH-1:0] pc);
        return TW'(pc >> (IDX + 2));
    endfunction

    genvar gl;
    generate
        for (gl = 0; gl < FETCH_WIDTH; gl++) begin : g_lane
            logic [XLEN_WIDTH-1:0] w_pc;
            logic [IW-1:0]         w_idx;
            logic [TW-1:0]         w_tag;
            logic                  w_hit;
            logic                  w_taken;
            logic [XLEN_WIDTH-1:0] w_target;

            assign w_pc  = bus.fetch_pc[gl*XLEN_WIDTH +: XLEN_WIDTH];
            assign w_idx = f_idx(w_pc);
            assign w_tag = f_tag(w_pc);

            // allocation only on miss guarantees at most one matching way
            always_comb begin
                w_hit    = 1'b0;
                w_taken  = 1'b0;
                w_target = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                        w_hit    = 1'b1;
                        w_taken  = r_cnt[w_idx][w][1];
                        w_target = {r_tgt[w_idx][w], 2'b00};
                    end
                end
            end

            assign bus.btb_hit[gl]                                  = w_hit;
            assign bus.btb_taken[gl]                                = w_taken;
            assign bus.btb_target[gl*XLEN_WIDTH +: XLEN_WIDTH]      = w_target;
        end
    endgenerate

    logic [IW-1:0] w_u_idx;
    logic [TW-1:0] w_u_tag;
    logic [GW-1:0] w_u_tgt;
    logic          w_u_hit;
    logic [WB-1:0] w_u_hit_way;
    logic          w_u_free;
    logic [WB-1:0] w_u_free_way;
    logic [WB-1:0] w_u_alloc_way;
    logic [WB-1:0] w_u_rr_next;

    assign w_u_idx = f_idx(bus.branch_addr);
    assign w_u_tag = f_tag(bus.branch_addr);
    assign w_u_tgt = GW'(bus.branch_target_addr >> 2);

    always_comb begin
        w_u_hit      = 1'b0;
        w_u_hit_way  = '0;
        w_u_free     = 1'b0;
        w_u_free_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_u_idx][w] && (r_tag[w_u_idx][w] == w_u_tag)) begin
                w_u_hit     = 1'b1;
                w_u_hit_way = WB'(w);
            end
        end
        // descending scan so the lowest-index invalid way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_u_idx][w]) begin
                w_u_free     = 1'b1;
                w_u_free_way = WB'(w);
            end
        end
    end

    assign w_u_alloc_way = w_u_free ? w_u_free_way : r_rr[w_u_idx];
    assign w_u_rr_next   = (r_rr[w_u_idx] == WB'(WAYS - 1)) ? '0 : r_rr[w_u_idx] + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_tag[s][w]   <= '0;
                    r_tgt[s][w]   <= '0;
                    r_cnt[s][w]   <= '0;
                end
            end
        end else if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                end
            end
        end else if (bus.branch_valid) begin
            if (w_u_hit) begin
                if (bus.branch_taken) begin
                    if (r_cnt[w_u_idx][w_u_hit_way] != 2'd3) begin
                        r_cnt[w_u_idx][w_u_hit_way] <= r_cnt[w_u_idx][w_u_hit_way] + 2'd1;
                    end
                    r_tgt[w_u_idx][w_u_hit_way] <= w_u_tgt;
                end else if (r_cnt[w_u_idx][w_u_hit_way] != 2'd0) begin
                    r_cnt[w_u_idx][w_u_hit_way] <= r_cnt[w_u_idx][w_u_hit_way] - 2'd1;
                end
            end else if (bus.branch_taken) begin
                r_valid[w_u_idx][w_u_alloc_way] <= 1'b1;
                r_tag[w_u_idx][w_u_alloc_way]   <= w_u_tag;
                r_tgt[w_u_idx][w_u_alloc_way]   <= w_u_tgt;
                r_cnt[w_u_idx][w_u_alloc_way]   <= 2'(CNT_INIT);
                // victim pointer only moves when a full set is overwritten
                if (!w_u_free) begin
                    r_rr[w_u_idx] <= w_u_rr_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed scenarios plus randomized traffic against a behavioural BTB model.
module tb_btb_assoc;
    localparam int XL    = 32;
    localparam int FW    = 2;
    localparam int NSETS = 32;
    localparam int NWAYS = 2;
    localparam int CINIT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btb_assoc_if #(.XLEN_WIDTH(XL), .FETCH_WIDTH(FW)) bus ();

    btb_assoc #(
        .XLEN_WIDTH(XL), .ENTRY_NUM(64), .WAYS(NWAYS), .FETCH_WIDTH(FW), .CNT_INIT(CINIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_val [NSETS][NWAYS];
    int unsigned m_tag [NSETS][NWAYS];
    logic [31:0] m_tgt [NSETS][NWAYS];
    int          m_cnt [NSETS][NWAYS];
    int          m_rr  [NSETS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int s = 0; s < NSETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NWAYS; w++) begin
                m_val[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0; m_cnt[s][w] = 0;
            end
        end
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        int s = int'((pc >> 2) % NSETS);
        for (int w = 0; w < NWAYS; w++)
            if (m_val[s][w] && m_tag[s][w] == (pc >> 7)) return w;
        return -1;
    endfunction

    function automatic void m_apply(input bit fl, input bit bv, input bit bt,
                                    input logic [31:0] ba, input logic [31:0] bta);
        int s = int'((ba >> 2) % NSETS);
        int w = m_find(ba);
        if (fl) begin
            for (int i = 0; i < NSETS; i++) begin
                m_rr[i] = 0;
                for (int j = 0; j < NWAYS; j++) m_val[i][j] = 0;
            end
            return;
        end
        if (!bv) return;
        if (w >= 0) begin
            if (bt) begin
                m_cnt[s][w] = (m_cnt[s][w] < 3) ? m_cnt[s][w] + 1 : 3;
                m_tgt[s][w] = bta & 32'hFFFF_FFFC;
            end else begin
                m_cnt[s][w] = (m_cnt[s][w] > 0) ? m_cnt[s][w] - 1 : 0;
            end
        end else if (bt) begin
            for (int j = NWAYS - 1; j >= 0; j--) if (!m_val[s][j]) w = j;
            if (w < 0) begin
                w = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % NWAYS;
            end
            m_val[s][w] = 1; m_tag[s][w] = ba >> 7;
            m_tgt[s][w] = bta & 32'hFFFF_FFFC; m_cnt[s][w] = CINIT;
        end
    endfunction

    task automatic check_lanes();
        for (int l = 0; l < FW; l++) begin
            logic [31:0] pc = bus.fetch_pc[l*XL +: XL];
            int s = int'((pc >> 2) % NSETS);
            int w = m_find(pc);
            chk($sformatf("hit%0d", l), 32'(bus.btb_hit[l]), (w >= 0) ? 32'd1 : 32'd0);
            chk($sformatf("taken%0d", l), 32'(bus.btb_taken[l]),
                (w >= 0 && m_cnt[s][w] >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("target%0d", l), bus.btb_target[l*XL +: XL],
                (w >= 0) ? m_tgt[s][w] : 32'd0);
        end
    endtask

    // drive one cycle: check pre-update lookup, then clock and advance the model
    task automatic step(input bit fl, input bit bv, input bit bt, input logic [31:0] ba,
                        input logic [31:0] bta, input logic [31:0] pc0, input logic [31:0] pc1);
        bus.flush = fl; bus.branch_valid = bv; bus.branch_taken = bt;
        bus.branch_addr = ba; bus.branch_target_addr = bta;
        bus.fetch_pc = {pc1, pc0};
        #2;
        check_lanes();
        @(posedge clk);
        m_apply(fl, bv, bt, ba, bta);
        #1;
        bus.branch_valid = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic expect_lane(input string tag, input int l, input bit h, input bit t,
                               input logic [31:0] tg);
        chk({tag, "_hit"}, 32'(bus.btb_hit[l]), 32'(h));
        chk({tag, "_taken"}, 32'(bus.btb_taken[l]), 32'(t));
        chk({tag, "_target"}, bus.btb_target[l*XL +: XL], tg);
    endtask

    initial begin
        logic [31:0] p0, p1, ba;
        bus.flush = 0; bus.branch_valid = 0; bus.branch_taken = 0;
        bus.branch_addr = 0; bus.branch_target_addr = 0;
        bus.fetch_pc = {32'h104, 32'h100};
        m_reset();
        #12;
        expect_lane("T1_rst_l0", 0, 0, 0, 0);
        expect_lane("T1_rst_l1", 1, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        step(0, 0, 0, 0, 0, 32'h100, 32'h104);
        // T2
        step(0, 1, 1, 32'h100, 32'h200, 32'h100, 32'h104);
        expect_lane("T2_next", 0, 1, 1, 32'h200);
        // T3
        step(0, 1, 0, 32'h100, 0, 32'h100, 32'h104);
        step(0, 1, 0, 32'h100, 0, 32'h100, 32'h104);
        expect_lane("T3_nt2", 0, 1, 0, 32'h200);
        step(0, 1, 0, 32'h100, 0, 32'h100, 32'h104);
        step(0, 1, 1, 32'h100, 32'h200, 32'h100, 32'h104);
        expect_lane("T3_t1", 0, 1, 0, 32'h200);
        step(0, 1, 1, 32'h100, 32'h200, 32'h100, 32'h104);
        expect_lane("T3_t2", 0, 1, 1, 32'h200);
        // T4
        step(0, 1, 1, 32'h180, 32'h380, 32'h100, 32'h180);
        step(0, 1, 1, 32'h200, 32'h403, 32'h100, 32'h180);
        expect_lane("T4_evict0", 0, 0, 0, 0);
        expect_lane("T4_keep180", 1, 1, 1, 32'h380);
        step(0, 0, 0, 0, 0, 32'h200, 32'h180);
        expect_lane("T4_new200", 0, 1, 1, 32'h400);
        step(0, 1, 1, 32'h280, 32'h480, 32'h200, 32'h180);
        expect_lane("T4_keep200", 0, 1, 1, 32'h400);
        expect_lane("T4_evict180", 1, 0, 0, 0);
        // T5
        step(1, 1, 1, 32'h300, 32'h500, 32'h300, 32'h200);
        expect_lane("T5_l0", 0, 0, 0, 0);
        expect_lane("T5_l1", 1, 0, 0, 0);
        // T6
        step(0, 1, 1, 32'h104, 32'h600, 32'h104, 32'h108);
        step(0, 1, 1, 32'h108, 32'h700, 32'h104, 32'h108);
        step(0, 1, 1, 32'h10C, 32'h800, 32'h104, 32'h108);
        expect_lane("T6_l0", 0, 1, 1, 32'h600);
        expect_lane("T6_l1", 1, 1, 1, 32'h700);
        bus.branch_valid = 1; bus.branch_taken = 1;
        bus.branch_addr = 32'h110; bus.branch_target_addr = 32'h900;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        expect_lane("T6_rst_l0", 0, 0, 0, 0);
        expect_lane("T6_rst_l1", 1, 0, 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b1; bus.branch_valid = 0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 32'h110, 32'h10C);

        for (int i = 0; i < 600; i++) begin
            p0 = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 3) << 2);
            p1 = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 3) << 2);
            ba = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 3) << 2);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 ba, $urandom, p0, (i % 5 == 0) ? p0 : p1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
